// File: rtl/mux2_pkg.sv
// Shared constants for the NAND-built 2:1 multiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux2_pkg;

   // Default data width of a, b, out and out_q.
   localparam int MUX2_DEFAULT_WIDTH = 1;

   // Select encodings: sel=0 picks a, sel=1 picks b.
   localparam logic MUX2_SEL_A = 1'b0;
   localparam logic MUX2_SEL_B = 1'b1;

endpackage : mux2_pkg

// File: rtl/mux2_bit.sv
// One-bit 2:1 mux made of four NAND-equivalent gates.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs continuously.
module mux2_bit (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic out
);

   logic ns;
   logic t0;
   logic t1;

   // Inverter built as a NAND with both inputs tied to sel.
   assign ns  = ~(sel & sel);
   // Path for a, enabled when sel is low.
   assign t0  = ~(a & ns);
   // Path for b, enabled when sel is high.
   assign t1  = ~(b & sel);
   // Final NAND merges both paths (OR of the enabled terms).
   assign out = ~(t0 & t1);

endmodule : mux2_bit

// File: rtl/mux2_gate.sv
// Bitwise 2:1 mux (out = sel ? b : a) from NAND cells, plus a registered copy.
// Latency: out 0 cycles, out_q 1 cycle; optional sel_chg under MUX2_SEL_CHANGE_EN.
// Backpressure: none; out_q updates on every clock edge, no enable.
module mux2_gate
   import mux2_pkg::*;
#(
   parameter int WIDTH = MUX2_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] out,
`ifdef MUX2_SEL_CHANGE_EN
   output logic             sel_chg,
`endif
   output logic [WIDTH-1:0] out_q
);

   // One gate-level mux per bit; all bits share the same select line.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      mux2_bit u_bit (
         .a   (a[i]),
         .b   (b[i]),
         .sel (sel),
         .out (out[i])
      );
   end

`ifdef MUX2_SEL_CHANGE_EN
   logic sel_d;

   // Registered result and previous select; reset clears both without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         sel_d <= MUX2_SEL_A;
      end else begin
         out_q <= out;
         sel_d <= sel;
      end
   end

   // High whenever sel differs from the value captured at the last edge.
   assign sel_chg = sel ^ sel_d;
`else
   // Registered result; reset clears it without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out;
      end
   end
`endif

endmodule : mux2_gate

// File: tb/tb_mux2_gate.sv
// Self-checking bench for mux2_gate at WIDTH=1 and WIDTH=8.
// Latency: checks out at 0 cycles and out_q at exactly 1 cycle.
// Backpressure: none exercised; optional sel_chg checked under MUX2_SEL_CHANGE_EN.
module tb_mux2_gate;
   import mux2_pkg::*;

   logic       clk;
   logic       rst;

   logic       a1, b1, s1;
   logic       out1, out_q1;

   logic [7:0] a8, b8;
   logic       s8;
   logic [7:0] out8, out_q8;

`ifdef MUX2_SEL_CHANGE_EN
   logic       sel_chg1, sel_chg8;
`endif

   int         checks = 0;
   int         errors = 0;

   // Reference state: expected registered value and last select seen at an edge.
   logic [7:0] exp_q;
   logic       prev_sel;

   // Truth table indexed by {a,b,sel}.
   logic [7:0] tt;

   mux2_gate #(.WIDTH(1)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .a       (a1),
      .b       (b1),
      .sel     (s1),
      .out     (out1),
`ifdef MUX2_SEL_CHANGE_EN
      .sel_chg (sel_chg1),
`endif
      .out_q   (out_q1)
   );

   mux2_gate #(.WIDTH(8)) u_dut8 (
      .clk     (clk),
      .rst     (rst),
      .a       (a8),
      .b       (b8),
      .sel     (s8),
      .out     (out8),
`ifdef MUX2_SEL_CHANGE_EN
      .sel_chg (sel_chg8),
`endif
      .out_q   (out_q8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one input set on the 8-bit DUT and check out, out_q before/after the edge.
   task automatic step8(input logic [7:0] da, input logic [7:0] db, input logic ds);
      logic [7:0] exp_out;
      @(negedge clk);
      a8 = da;
      b8 = db;
      s8 = ds;
      #1;
      exp_out = (ds == MUX2_SEL_B) ? db : da;
      check("out", out8, exp_out);
      check("out_q_hold", out_q8, exp_q);
`ifdef MUX2_SEL_CHANGE_EN
      check("sel_chg", {7'b0, sel_chg8}, {7'b0, ds ^ prev_sel});
`endif
      @(posedge clk);
      #1;
      exp_q    = exp_out;
      prev_sel = ds;
      check("out_q", out_q8, exp_q);
   endtask

   initial begin
      logic [2:0]  idx;
      logic [7:0]  ra, rb;
      logic        rs;

      tt       = 8'b1101_1000;
      rst      = 1'b1;
      a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
      a8 = 8'h00; b8 = 8'h00; s8 = 1'b0;
      exp_q    = 8'h00;
      prev_sel = 1'b0;

      // Reset state.
      #3;
      check("rst_out_q1", {7'b0, out_q1}, 8'h00);
      check("rst_out_q8", out_q8, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: WIDTH=1 truth table, 10 time units per combination.
      for (int i = 0; i < 8; i++) begin
         idx = i[2:0];
         a1  = idx[2];
         b1  = idx[1];
         s1  = idx[0];
         #5;
         check($sformatf("tt_%0d", i), {7'b0, out1}, {7'b0, tt[idx]});
         #5;
      end

      // Test 2: select switch; out_q keeps A5 until the next edge.
      step8(8'hA5, 8'h3C, 1'b0);
      step8(8'hA5, 8'h3C, 1'b1);

      // Test 3: asynchronous reset between edges, then release.
      step8(8'hFF, 8'h00, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", out_q8, 8'h00);
      exp_q    = 8'h00;
      prev_sel = 1'b0;
      a8 = 8'hF0; b8 = 8'h0F; s8 = 1'b1;
      #1;
      check("out_in_rst", out8, 8'h0F);
`ifdef MUX2_SEL_CHANGE_EN
      check("sel_chg_in_rst", {7'b0, sel_chg8}, 8'h01);
`endif
      @(posedge clk);
      #1;
      check("rst_hold", out_q8, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_no_edge", out_q8, 8'h00);
      @(posedge clk);
      #1;
      check("rel_capture", out_q8, 8'h0F);
      exp_q    = 8'h0F;
      prev_sel = 1'b1;

      // Test 4: equal data, toggling select keeps both outputs constant.
      for (int i = 0; i < 6; i++) begin
         step8(8'h55, 8'h55, i[0]);
      end

      // Test 5: select sequence 0,0,1,1,0 (sel_chg checked inside step8).
      step8(8'h12, 8'h34, 1'b0);
      step8(8'h12, 8'h34, 1'b0);
      step8(8'h12, 8'h34, 1'b1);
      step8(8'h12, 8'h34, 1'b1);
      step8(8'h12, 8'h34, 1'b0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom_range(1, 0));
         step8(ra, rb, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mux2_gate
